keypad_input_unit: RTL and testbench
====================================

// Module: keypad_input_unit
// PURPOSE
//  Services keypad reads. data_mem asserts input_enable for a load in the IO keypad window.
//  This block scans a 4x4 matrix keypad, debounces it and accumulates up to 32 binary digits.
//  It returns the value on '#'. input_busy holds hazard_unit's MEM stall.
//  input_data and input_done feed mem_wb_reg; bit_count and display_value feed seven_seg_unit.
// PARAMETERS
//  DATA_WIDTH      32      accumulator width (ISA_WIDTH)
//  SCAN_PERIOD_CYC 50000   cycles each column is driven before rows are sampled
//  DEBOUNCE_CYC    500000  cycles a key (or release) must be stable to count
// PORTS
//  clk            in   1   system clock, all state on rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  input_enable   in   1   level from data_mem, high while the keypad load sits in MEM
//  row_in         in   4   keypad rows, active-low, externally pulled up
//  col_out        out  4   keypad columns, one driven low at a time, others high
//  input_data     out  32  confirmed value, held until the next read starts
//  input_done     out  1   one-cycle pulse: input_data valid, release the stall
//  input_busy     out  1   read in progress (to hazard_unit)
//  bit_count      out  6   digits entered so far, 0..32
//  display_value  out  32  live accumulator for the 7-seg display
// BEHAVIOUR
//  Reset: state=IDLE, col_out=4'b1110, input_data=0, input_done=0, input_busy=0, bit_count=0, display_value=0.
//  FSM states: IDLE, SCAN, DEBOUNCE, RELEASE, DONE.
//   IDLE: on input_enable=1, clear accumulator and bit_count, go to SCAN with column 0.
//   SCAN: drive col_out low on the current column.
//    - After SCAN_PERIOD_CYC cycles, sample row_in.
//    - If exactly one row is low, latch {row,col} and go to DEBOUNCE.
//    - If no row is low, or more than one row is low, rotate to the next column (3 wraps to 0).
//   DEBOUNCE: keep the same column. The latched row must stay low for DEBOUNCE_CYC consecutive cycles.
//    - Any change returns to SCAN with the same column.
//    - On success, execute the key and go to RELEASE.
//   RELEASE: keep the column. Wait for row_in=4'hF for DEBOUNCE_CYC consecutive cycles; a bounce restarts the count.
//    - Then go to SCAN, or to DONE if the executed key was confirm.
//   DONE: input_data<=accumulator, input_done=1 for exactly this cycle, then IDLE.
//  Key map (rows 0..3 x cols 0..3) = "123A" / "456B" / "789C" / "*0#D".
//   '1': acc<=(acc<<1)|1, bit_count+1.
//   '0': acc<=acc<<1, bit_count+1.
//   '*': backspace, acc<=acc>>1, bit_count-1.
//   'C': acc<=0, bit_count<=0.
//   '#': confirm.
//   All other keys are ignored but still wait for release.
//  Boundaries:
//   - A digit key at bit_count=32 is ignored.
//   - '*' at bit_count=0 is ignored.
//   - '#' with 0 digits confirms the value 0.
//  input_busy=1 in SCAN, DEBOUNCE and RELEASE. It is 0 in IDLE and DONE.
//   hazard_unit advances the pipeline on the edge where input_done=1.
//   IDLE therefore sees the next instruction's input_enable, so back-to-back reads work.
//  Abort: input_enable=0 in SCAN, DEBOUNCE or RELEASE (pipeline flush) goes to IDLE next cycle.
//   No input_done is produced; input_data and display_value keep their old values; col_out returns to 4'b1110.
//  input_enable=1 in DONE is not a new request; a start is recognised only in IDLE.
//  display_value tracks the accumulator every cycle; bit_count is its digit count.
//  Asynchronous reset at any point returns to the reset values and discards partial input.
//  row_in passes through a 2-flop synchroniser before any use.
//   Sampling latency from SCAN_PERIOD expiry is 2 cycles; this counts inside the period.
//  Counters are sized $clog2(max(SCAN_PERIOD_CYC,DEBOUNCE_CYC)+1) and saturate, never wrap.
// STRUCTURE
//  definitions.v gains:
//   - KEY_* codes for 0, 1, '*', '#', 'C'.
//   - KP_ST_* state encodings.
//   - IO keypad address constant (shared with data_mem).
//  Sub-module keypad_scanner:
//   - Owns the synchroniser, column rotation, debounce and release timing.
//   - Emits key_valid (1-cycle pulse) and key_code[3:0].
//   - Inputs: scan_en and scan_abort.
//  The top level owns the FSM handshake, accumulator, bit_count and the done/abort logic.
// TESTING (bench uses SCAN_PERIOD_CYC=4, DEBOUNCE_CYC=8)
//  1. Raise input_enable, press 1,0,1,1 then '#'.
//     -> input_data=32'h0000000B and one input_done pulse; input_busy high from the cycle after enable until DONE.
//  2. Press 1,1,'*',0 then '#' -> 32'h00000002, bit_count=2 before confirm.
//  3. Enter 33 '1' digits then '#' -> 32'hFFFFFFFF, bit_count saturates at 32.
//  4. Bouncing '1', low for 3 cycles then high, repeated.
//     -> no digit registered; a clean hold registers exactly one digit; holding it 100 cycles gives still one digit.
//  5. After 2 digits, drop input_enable.
//     -> IDLE next cycle, no input_done, input_data unchanged. Reassert it -> accumulator starts from 0.
//  6. Two back-to-back reads (input_enable stays high): enter 1 then 0.
//     -> two done pulses, values 1 and 0. Assert rst_n=0 mid-scan -> all outputs at reset values immediately.

Source files
------------

// File: rtl/keypad_input_unit_pkg.sv
// Shared types and constants for the keypad input unit.
// Key codes are {row, col} of the 4x4 matrix "123A/456B/789C/*0#D".
package keypad_input_unit_pkg;

  typedef enum logic [2:0] {
    KP_ST_IDLE     = 3'd0,
    KP_ST_SCAN     = 3'd1,
    KP_ST_DEBOUNCE = 3'd2,
    KP_ST_RELEASE  = 3'd3,
    KP_ST_DONE     = 3'd4
  } kp_state_t;

  localparam logic [3:0] KEY_1    = 4'h0;
  localparam logic [3:0] KEY_C    = 4'hB;
  localparam logic [3:0] KEY_STAR = 4'hC;
  localparam logic [3:0] KEY_0    = 4'hD;
  localparam logic [3:0] KEY_HASH = 4'hE;

  localparam logic [31:0] IO_KEYPAD_ADDR = 32'hFFFF_FC10;

  // {hit, row}: hit only when exactly one active-low row is asserted
  function automatic logic [2:0] row_hit(input logic [3:0] rows);
    logic [2:0] r;
    case (rows)
      4'b1110: r = 3'b100;
      4'b1101: r = 3'b101;
      4'b1011: r = 3'b110;
      4'b0111: r = 3'b111;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keypad_input_unit_scanner.sv
// Column scanner with row synchroniser, debounce and release timing.
// Held at column 0 with a cleared counter while not enabled.
module keypad_scanner
  import keypad_input_unit_pkg::*;
#(
  parameter int SCAN_PERIOD_CYC = 50000,
  parameter int DEBOUNCE_CYC    = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_scan_en,
  input  logic       i_scan_abort,
  input  logic [3:0] i_row,
  output logic [3:0] o_col,
  output logic       o_key_valid,
  output logic [3:0] o_key_code,
  output logic       o_released
);

  localparam int CMAX = (SCAN_PERIOD_CYC > DEBOUNCE_CYC) ?
                        SCAN_PERIOD_CYC : DEBOUNCE_CYC;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SP_LAST = CW'(SCAN_PERIOD_CYC - 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  kp_state_t     r_phase;
  logic [1:0]    r_col;
  logic [1:0]    r_row;
  logic [CW-1:0] r_cnt;
  logic          r_key_valid;
  logic [3:0]    r_code;
  logic          r_released;

  logic [2:0]    w_hit;
  logic [3:0]    w_hold_pat;
  logic [CW-1:0] w_cnt_inc;

  assign w_hit      = row_hit(r_sync2);
  assign w_hold_pat = ~(4'b0001 << r_row);
  assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  assign o_col       = ~(4'b0001 << r_col);
  assign o_key_valid = r_key_valid;
  assign o_key_code  = r_code;
  assign o_released  = r_released;

  // two-flop synchroniser on the raw rows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
    end else begin
      r_sync1 <= i_row;
      r_sync2 <= r_sync1;
    end
  end

  // scan / debounce / release sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase     <= KP_ST_SCAN;
      r_col       <= 2'd0;
      r_row       <= 2'd0;
      r_cnt       <= '0;
      r_key_valid <= 1'b0;
      r_code      <= 4'h0;
      r_released  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      r_released  <= 1'b0;
      if (!i_scan_en || i_scan_abort) begin
        r_phase <= KP_ST_SCAN;
        r_col   <= 2'd0;
        r_cnt   <= '0;
      end else begin
        unique case (r_phase)
          KP_ST_SCAN: begin
            if (r_cnt >= SP_LAST) begin
              r_cnt <= '0;
              if (w_hit[2]) begin
                r_row   <= w_hit[1:0];
                r_phase <= KP_ST_DEBOUNCE;
              end else begin
                r_col <= r_col + 2'd1;
              end
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          KP_ST_DEBOUNCE: begin
            if (r_sync2 != w_hold_pat) begin
              r_cnt   <= '0;
              r_phase <= KP_ST_SCAN;
            end else if (r_cnt >= DB_LAST) begin
              r_cnt       <= '0;
              r_key_valid <= 1'b1;
              r_code      <= {r_row, r_col};
              r_phase     <= KP_ST_RELEASE;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          KP_ST_RELEASE: begin
            if (r_sync2 != 4'hF) begin
              r_cnt <= '0;
            end else if (r_cnt >= DB_LAST) begin
              r_cnt      <= '0;
              r_released <= 1'b1;
              r_phase    <= KP_ST_SCAN;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: begin
            r_cnt   <= '0;
            r_phase <= KP_ST_SCAN;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/keypad_input_unit.sv
// Keypad read unit: handshake with MEM, binary digit accumulator,
// confirm/abort handling; scanning lives in keypad_scanner.
module keypad_input_unit
  import keypad_input_unit_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int SCAN_PERIOD_CYC = 50000,
  parameter int DEBOUNCE_CYC    = 500000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  input_enable,
  input  logic [3:0]            row_in,
  output logic [3:0]            col_out,
  output logic [DATA_WIDTH-1:0] input_data,
  output logic                  input_done,
  output logic                  input_busy,
  output logic [5:0]            bit_count,
  output logic [DATA_WIDTH-1:0] display_value
);

  localparam logic [5:0] MAX_BITS = 6'(DATA_WIDTH);

  kp_state_t             r_state;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [5:0]            r_bits;
  logic                  r_confirm;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_done;
  logic                  r_busy;

  logic                  w_scan_en;
  logic                  w_abort;
  logic                  w_key_valid;
  logic [3:0]            w_code;
  logic                  w_released;

  assign w_scan_en = (r_state == KP_ST_SCAN);
  assign w_abort   = w_scan_en && !input_enable;

  keypad_scanner #(
    .SCAN_PERIOD_CYC (SCAN_PERIOD_CYC),
    .DEBOUNCE_CYC    (DEBOUNCE_CYC)
  ) u_scanner (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_scan_en    (w_scan_en),
    .i_scan_abort (w_abort),
    .i_row        (row_in),
    .o_col        (col_out),
    .o_key_valid  (w_key_valid),
    .o_key_code   (w_code),
    .o_released   (w_released)
  );

  assign input_data    = r_data;
  assign input_done    = r_done;
  assign input_busy    = r_busy;
  assign bit_count     = r_bits;
  assign display_value = r_acc;

  // read handshake FSM and key execution
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= KP_ST_IDLE;
      r_acc     <= '0;
      r_bits    <= 6'd0;
      r_confirm <= 1'b0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        KP_ST_IDLE: begin
          if (input_enable) begin
            r_acc     <= '0;
            r_bits    <= 6'd0;
            r_confirm <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= KP_ST_SCAN;
          end
        end
        KP_ST_SCAN: begin
          if (!input_enable) begin
            r_busy  <= 1'b0;
            r_state <= KP_ST_IDLE;
          end else if (w_released && r_confirm) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_data  <= r_acc;
            r_state <= KP_ST_DONE;
          end else if (w_key_valid) begin
            unique case (1'b1)
              (w_code == KEY_1): begin
                if (r_bits < MAX_BITS) begin
                  r_acc  <= {r_acc[DATA_WIDTH-2:0], 1'b1};
                  r_bits <= r_bits + 6'd1;
                end
              end
              (w_code == KEY_0): begin
                if (r_bits < MAX_BITS) begin
                  r_acc  <= {r_acc[DATA_WIDTH-2:0], 1'b0};
                  r_bits <= r_bits + 6'd1;
                end
              end
              (w_code == KEY_STAR): begin
                if (r_bits != 6'd0) begin
                  r_acc  <= {1'b0, r_acc[DATA_WIDTH-1:1]};
                  r_bits <= r_bits - 6'd1;
                end
              end
              (w_code == KEY_C): begin
                r_acc  <= '0;
                r_bits <= 6'd0;
              end
              (w_code == KEY_HASH): r_confirm <= 1'b1;
              default: ;
            endcase
          end
        end
        KP_ST_DONE: r_state <= KP_ST_IDLE;
        default:    r_state <= KP_ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_input_unit.sv
// Directed bench for keypad_input_unit with a keypad matrix model
// and a key-level reference model of the accumulator.
module tb_keypad_input_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        input_enable;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [31:0] input_data;
  logic        input_done;
  logic        input_busy;
  logic [5:0]  bit_count;
  logic [31:0] display_value;

  keypad_input_unit #(
    .DATA_WIDTH      (32),
    .SCAN_PERIOD_CYC (4),
    .DEBOUNCE_CYC    (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .input_enable  (input_enable),
    .row_in        (row_in),
    .col_out       (col_out),
    .input_data    (input_data),
    .input_done    (input_done),
    .input_busy    (input_busy),
    .bit_count     (bit_count),
    .display_value (display_value)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic        key_dn = 1'b0;
  logic [1:0]  krow = 2'd0;
  logic [1:0]  kcol = 2'd0;
  logic        chk_en = 1'b0;
  logic [31:0] m_acc = 32'd0;
  int          m_cnt = 0;
  logic        m_busy = 1'b0;
  logic [31:0] exp_data = 32'd0;
  int          exp_ndone = 0;
  int          n_done = 0;
  logic [31:0] last_data = 32'd0;
  logic        prev_done = 1'b0;
  string       km = "123A456B789C*0#D";

  // physical matrix: pressed key pulls its row low when its column is driven
  always_comb begin
    row_in = 4'hF;
    if (key_dn && !col_out[kcol]) row_in[krow] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic select_key(input byte k);
    for (int i = 0; i < 16; i++)
      if (km[i] == k) begin
        krow = 2'(i / 4);
        kcol = 2'(i % 4);
      end
  endtask

  task automatic model_key(input byte k);
    case (k)
      "1": if (m_cnt < 32) begin m_acc = m_acc * 2 + 1; m_cnt++; end
      "0": if (m_cnt < 32) begin m_acc = m_acc * 2; m_cnt++; end
      "*": if (m_cnt > 0) begin m_acc = m_acc / 2; m_cnt--; end
      "C": begin m_acc = 0; m_cnt = 0; end
      "#": begin exp_ndone++; m_acc = 0; m_cnt = 0; end
      default: ;
    endcase
  endtask

  task automatic press(input byte k, input int hold);
    chk_en = 1'b0;
    if (k == "#") exp_data = m_acc;
    select_key(k);
    key_dn = 1'b1;
    repeat (hold) @(posedge clk);
    key_dn = 1'b0;
    repeat (40) @(posedge clk);
    model_key(k);
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  // settled-state compare against the key-level model
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("display_value", display_value, m_acc);
      check("bit_count", {26'd0, bit_count}, m_cnt);
      check("input_busy", {31'd0, input_busy}, {31'd0, m_busy});
      check("done_count", n_done, exp_ndone);
    end
  end

  // done pulse monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (input_done) begin
        n_done++;
        last_data = input_data;
        check("done_data", input_data, exp_data);
        check("done_one_cycle", {31'd0, prev_done}, 32'd0);
        check("busy_in_done", {31'd0, input_busy}, 32'd0);
      end
      prev_done = input_done;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    input_enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_col", {28'd0, col_out}, 32'hE);
    check("rst_data", input_data, 32'd0);
    check("rst_done", {31'd0, input_done}, 32'd0);
    check("rst_busy", {31'd0, input_busy}, 32'd0);
    check("rst_bits", {26'd0, bit_count}, 32'd0);
    check("rst_disp", display_value, 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);

    // 1: 1011 then confirm
    @(negedge clk);
    chk_en = 1'b0;
    input_enable = 1'b1;
    check("busy_pre", {31'd0, input_busy}, 32'd0);
    @(posedge clk);
    #1;
    check("busy_rise", {31'd0, input_busy}, 32'd1);
    m_busy = 1'b1;
    chk_en = 1'b1;
    press("1", 60); press("0", 60); press("1", 60); press("1", 60);
    check("t1_acc", display_value, 32'hB);
    press("#", 60);
    check("t1_data", last_data, 32'h0000000B);
    check("t1_ndone", n_done, 1);

    // 2: backspace
    press("1", 60); press("1", 60); press("*", 60); press("0", 60);
    check("t2_bits", {26'd0, bit_count}, 32'd2);
    press("#", 60);
    check("t2_data", last_data, 32'h00000002);

    // 3: 33 ones saturate at 32 digits; stray keys ignored
    for (int i = 0; i < 33; i++) press("1", 60);
    press("5", 60);
    check("t3_bits", {26'd0, bit_count}, 32'd32);
    check("t3_acc", display_value, 32'hFFFFFFFF);
    press("#", 60);
    check("t3_data", last_data, 32'hFFFFFFFF);

    // 4: bouncing key, then a long clean hold
    chk_en = 1'b0;
    select_key("1");
    for (int i = 0; i < 12; i++) begin
      key_dn = 1'b1;
      repeat (3) @(posedge clk);
      key_dn = 1'b0;
      repeat (3) @(posedge clk);
    end
    repeat (40) @(posedge clk);
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    check("t4_bounce", {26'd0, bit_count}, 32'd0);
    press("1", 100);
    check("t4_hold", {26'd0, bit_count}, 32'd1);

    // 5: abort after 2 digits, then restart
    press("0", 60);
    @(negedge clk);
    chk_en = 1'b0;
    input_enable = 1'b0;
    @(posedge clk);
    #1;
    check("t5_busy", {31'd0, input_busy}, 32'd0);
    check("t5_col", {28'd0, col_out}, 32'hE);
    m_busy = 1'b0;
    chk_en = 1'b1;
    repeat (6) @(posedge clk);
    check("t5_disp", display_value, 32'h2);
    check("t5_data", input_data, 32'hFFFFFFFF);
    check("t5_ndone", n_done, 3);
    @(negedge clk);
    chk_en = 1'b0;
    input_enable = 1'b1;
    @(posedge clk);
    #1;
    m_acc = 0;
    m_cnt = 0;
    m_busy = 1'b1;
    chk_en = 1'b1;
    check("t5_restart", display_value, 32'd0);

    // 6: back-to-back reads, then reset mid-scan
    press("1", 60); press("#", 60);
    check("t6_data1", last_data, 32'd1);
    press("0", 60); press("#", 60);
    check("t6_data0", last_data, 32'd0);
    check("t6_ndone", n_done, 5);
    press("1", 60);
    chk_en = 1'b0;
    select_key("1");
    key_dn = 1'b1;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst2_col", {28'd0, col_out}, 32'hE);
    check("rst2_data", input_data, 32'd0);
    check("rst2_done", {31'd0, input_done}, 32'd0);
    check("rst2_busy", {31'd0, input_busy}, 32'd0);
    check("rst2_bits", {26'd0, bit_count}, 32'd0);
    check("rst2_disp", display_value, 32'd0);
    key_dn = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
